// File: rtl/store_queue_fwd.sv
// Store queue: in-order FIFO of pending stores that issue to memory once committed,
// with a combinational byte-granular store-to-load forwarding path.
module store_queue_fwd #(
    parameter int DEPTH        = 8,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int ID_W         = 6,
    parameter int RETIRE_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W/8-1:0]          push_be,
    input  logic [DATA_W-1:0]            push_data,
    input  logic [ID_W-1:0]              push_id,
    input  logic [RETIRE_PORTS-1:0]      commit_valid,
    input  logic [RETIRE_PORTS*ID_W-1:0] commit_id,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [DATA_W/8-1:0]          out_be,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         ld_valid,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [DATA_W/8-1:0]          ld_be,
    output logic                         ld_hit,
    output logic                         ld_partial,
    output logic [DATA_W-1:0]            ld_data,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OFF_W = $clog2(BE_W);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Control state
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] committed_reg, committed_next;

    // Payload storage, never reset
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [BE_W-1:0]   be_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ID_W-1:0]   id_mem   [DEPTH];

    logic             push_fire;
    logic             pop_fire;
    logic [DEPTH-1:0] commit_hit;
    logic [DEPTH-1:0] comm_after;
    logic [DEPTH-1:0] fwd_match;
    logic [CNT_W-1:0] committed_count;
    logic [CNT_W-1:0] push_ext;
    logic [CNT_W-1:0] pop_ext;

    logic [PTR_W-1:0]  fwd_idx;
    logic [BE_W-1:0]   supplied;
    logic [DATA_W-1:0] fwd_bytes;
    logic [BE_W-1:0]   want;
    logic [BE_W-1:0]   got;

    assign push_ready = (count_reg < CNT_FULL);
    assign out_valid  = valid_reg[head_reg] & committed_reg[head_reg];
    assign out_addr   = addr_mem[head_reg];
    assign out_be     = be_mem[head_reg];
    assign out_data   = data_mem[head_reg];
    assign empty      = (count_reg == '0);
    assign count      = count_reg;

    assign push_fire = push_valid & push_ready & ~flush;
    assign pop_fire  = out_valid & out_ready;
    assign push_ext  = {{(CNT_W-1){1'b0}}, push_fire};
    assign pop_ext   = {{(CNT_W-1){1'b0}}, pop_fire};

    // Per-entry commit match and forwarding address match
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic id_match;

        always_comb begin
            id_match = 1'b0;
            for (int p = 0; p < RETIRE_PORTS; p++) begin
                if (commit_valid[p] && (commit_id[p*ID_W +: ID_W] == id_mem[gi]))
                    id_match = 1'b1;
            end
        end

        assign commit_hit[gi] = valid_reg[gi] & ~committed_reg[gi] & id_match;

        // An entry leaving this cycle must not feed a load.
        assign fwd_match[gi] = valid_reg[gi]
                             & ~(pop_fire & (head_reg == PTR_W'(gi)))
                             & (addr_mem[gi][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W]);
    end

    assign comm_after = committed_reg | commit_hit;

    always_comb begin
        committed_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            committed_count = committed_count
                            + {{(CNT_W-1){1'b0}}, (valid_reg[i] & comm_after[i])};
        end
    end

    always_comb begin
        valid_next     = valid_reg;
        committed_next = comm_after;
        head_next      = head_reg;
        tail_next      = tail_reg;
        count_next     = count_reg;

        if (pop_fire) begin
            valid_next[head_reg]     = 1'b0;
            committed_next[head_reg] = 1'b0;
            head_next                = head_reg + PTR_ONE;
        end

        if (flush) begin
            // Committed entries form the contiguous run starting at head; keep only those.
            valid_next     = valid_next & comm_after;
            committed_next = committed_next & valid_next;
            tail_next      = head_reg + committed_count[PTR_W-1:0];
            count_next     = committed_count - pop_ext;
        end else begin
            if (push_fire) begin
                valid_next[tail_reg]     = 1'b1;
                committed_next[tail_reg] = 1'b0;
                tail_next                = tail_reg + PTR_ONE;
            end
            count_next = count_reg + push_ext - pop_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            valid_reg     <= '0;
            committed_reg <= '0;
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            valid_reg     <= valid_next;
            committed_reg <= committed_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            addr_mem[tail_reg] <= push_addr;
            be_mem[tail_reg]   <= push_be;
            data_mem[tail_reg] <= push_data;
            id_mem[tail_reg]   <= push_id;
        end
    end

    // Walk oldest to youngest from head so younger matches overwrite older ones.
    always_comb begin
        supplied  = '0;
        fwd_bytes = '0;
        fwd_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PTR_W'(k);
            if (fwd_match[fwd_idx]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be_mem[fwd_idx][b]) begin
                        supplied[b]          = 1'b1;
                        fwd_bytes[b*8 +: 8]  = data_mem[fwd_idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign want       = ld_valid ? ld_be : '0;
    assign got        = want & supplied;
    assign ld_hit     = (want != '0) && (got == want);
    assign ld_partial = (got != '0) && (got != want);

    always_comb begin
        ld_data = '0;
        for (int b = 0; b < BE_W; b++) begin
            if (got[b])
                ld_data[b*8 +: 8] = fwd_bytes[b*8 +: 8];
        end
    end

endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd (DEPTH=4, DATA_W=32) with hand-computed expectations.
module tb_store_queue_fwd;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 6;
    localparam int RP     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid;
    logic              push_ready;
    logic [ADDR_W-1:0] push_addr;
    logic [3:0]        push_be;
    logic [DATA_W-1:0] push_data;
    logic [ID_W-1:0]   push_id;
    logic [RP-1:0]     commit_valid;
    logic [RP*ID_W-1:0] commit_id;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [3:0]        out_be;
    logic [DATA_W-1:0] out_data;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [3:0]        ld_be;
    logic              ld_hit;
    logic              ld_partial;
    logic [DATA_W-1:0] ld_data;
    logic              empty;
    logic [2:0]        count;

    int checks   = 0;
    int failures = 0;

    store_queue_fwd #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .RETIRE_PORTS(RP)
    ) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_be(push_be), .push_data(push_data), .push_id(push_id),
        .commit_valid(commit_valid), .commit_id(commit_id), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_be(out_be), .out_data(out_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hit(ld_hit), .ld_partial(ld_partial), .ld_data(ld_data),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                        input logic [3:0] be, input logic [DATA_W-1:0] d);
        push_valid = 1'b1;
        push_id    = id;
        push_addr  = a;
        push_be    = be;
        push_data  = d;
    endtask

    task automatic commit2(input logic [1:0] v, input logic [ID_W-1:0] id1, input logic [ID_W-1:0] id0);
        commit_valid = v;
        commit_id    = {id1, id0};
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_be = '0; push_data = '0;
        push_id = '0; commit_valid = '0; commit_id = '0; flush = 1'b0; out_ready = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_be = '0;
        tick; tick;
        rst = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h100; ld_be = 4'hF;
        settle;
        check("rst_push_ready", push_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_ld_hit", ld_hit, 0);
        check("rst_ld_partial", ld_partial, 0);
        ld_valid = 1'b0;
        $display("txn reset done");

        // Basic flow
        push(3, 32'h100, 4'hF, 32'hDEADBEEF);
        settle;
        check("basic_push_ready", push_ready, 1);
        tick;
        push_valid = 1'b0;
        commit2(2'b11, 6'd9, 6'd3);
        settle;
        check("basic_count1", count, 1);
        check("basic_not_yet_valid", out_valid, 0);
        tick;
        commit_valid = '0;
        settle;
        check("basic_out_valid", out_valid, 1);
        check("basic_out_data", out_data, 32'hDEADBEEF);
        check("basic_out_addr", out_addr, 32'h100);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        settle;
        check("basic_empty", empty, 1);
        check("basic_out_valid_after_pop", out_valid, 0);
        $display("txn basic flow done");

        // Full, simultaneous events and wrap
        for (int i = 0; i < 4; i++) begin
            push(6'(10 + i), 32'h10 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i));
            settle;
            check("full_push_ready", push_ready, 1);
            tick;
        end
        push(20, 32'h30, 4'hF, 32'hB0);
        settle;
        check("full_push_ready0", push_ready, 0);
        check("full_count4", count, 4);
        check("full_uncommitted_no_out", out_valid, 0);
        tick;
        push_valid = 1'b0;
        commit2(2'b11, 6'd11, 6'd10);
        tick;
        commit2(2'b11, 6'd13, 6'd12);
        settle;
        check("full_head_committed", out_valid, 1);
        check("full_head_data", out_data, 32'hA0);
        tick;
        commit_valid = '0;
        out_ready = 1'b1;
        push(20, 32'h30, 4'hF, 32'hB0);
        settle;
        check("simul_push_refused", push_ready, 0);
        tick;
        push_valid = 1'b0;
        settle;
        check("simul_count", count, 3);
        check("simul_next_head", out_data, 32'hA1);
        tick;
        out_ready = 1'b0;
        settle;
        check("wrap_count2", count, 2);
        push(14, 32'h20, 4'hF, 32'hA4);
        tick;
        push(15, 32'h24, 4'hF, 32'hA5);
        tick;
        push_valid = 1'b0;
        settle;
        check("wrap_count4", count, 4);
        commit2(2'b11, 6'd15, 6'd14);
        tick;
        commit_valid = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            settle;
            check("wrap_order", out_data, 32'hA2 + 32'(j));
            tick;
        end
        out_ready = 1'b0;
        settle;
        check("wrap_empty", empty, 1);
        $display("txn full/wrap done");

        // Byte forwarding (entries straddle the pointer wrap)
        push(1, 32'h200, 4'h3, 32'h0000AAAA);
        tick;
        push(2, 32'h200, 4'h2, 32'h0000BB00);
        tick;
        push_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h200; ld_be = 4'h3;
        settle;
        check("fwd_hit", ld_hit, 1);
        check("fwd_hit_partial", ld_partial, 0);
        check("fwd_data", ld_data, 32'h0000BBAA);
        ld_be = 4'hF;
        settle;
        check("fwd_partial_hit", ld_hit, 0);
        check("fwd_partial", ld_partial, 1);
        check("fwd_partial_data", ld_data, 32'h0000BBAA);
        ld_addr = 32'h202; ld_be = 4'h1;
        settle;
        check("fwd_word_match", ld_hit, 1);
        check("fwd_word_data", ld_data, 32'h000000AA);
        ld_addr = 32'h204; ld_be = 4'hF;
        settle;
        check("fwd_miss_hit", ld_hit, 0);
        check("fwd_miss_partial", ld_partial, 0);
        check("fwd_miss_data", ld_data, 0);
        ld_addr = 32'h200; ld_be = 4'h0;
        settle;
        check("fwd_be0_hit", ld_hit, 0);
        check("fwd_be0_partial", ld_partial, 0);
        ld_valid = 1'b0; ld_be = 4'h3;
        settle;
        check("fwd_novalid_hit", ld_hit, 0);
        commit2(2'b11, 6'd2, 6'd1);
        tick;
        commit_valid = '0;
        ld_valid = 1'b1; ld_be = 4'h1; out_ready = 1'b1;
        settle;
        check("fwd_pop_out_valid", out_valid, 1);
        check("fwd_pop_excluded", ld_hit, 0);
        check("fwd_pop_data", ld_data, 0);
        tick;
        out_ready = 1'b0; ld_be = 4'h3;
        settle;
        check("fwd_after_pop_partial", ld_partial, 1);
        check("fwd_after_pop_data", ld_data, 32'h0000BB00);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0; ld_valid = 1'b0;
        settle;
        check("fwd_empty", empty, 1);
        $display("txn forwarding done");

        // Flush with simultaneous push
        push(30, 32'h40, 4'hF, 32'hC0);
        tick;
        push(31, 32'h44, 4'hF, 32'hC1);
        tick;
        push(32, 32'h48, 4'hF, 32'hC2);
        tick;
        push_valid = 1'b0;
        commit2(2'b01, 6'd0, 6'd30);
        tick;
        commit_valid = '0;
        flush = 1'b1;
        push(33, 32'h4C, 4'hF, 32'hC3);
        settle;
        check("flush_pre_count", count, 3);
        tick;
        flush = 1'b0; push_valid = 1'b0;
        settle;
        check("flush_count1", count, 1);
        check("flush_out_valid", out_valid, 1);
        check("flush_out_data", out_data, 32'hC0);
        check("flush_push_ready", push_ready, 1);
        ld_valid = 1'b1; ld_addr = 32'h44; ld_be = 4'hF;
        settle;
        check("flush_dropped_hit", ld_hit, 0);
        check("flush_dropped_partial", ld_partial, 0);
        ld_addr = 32'h4C;
        settle;
        check("flush_push_discarded", ld_hit, 0);
        ld_valid = 1'b0;
        push(34, 32'h50, 4'hF, 32'hC4);
        tick;
        push_valid = 1'b0;
        commit2(2'b01, 6'd0, 6'd34);
        tick;
        commit_valid = '0;
        out_ready = 1'b1;
        settle;
        check("flush_issue_c0", out_data, 32'hC0);
        tick;
        settle;
        check("flush_issue_c4", out_data, 32'hC4);
        check("flush_count_after", count, 1);
        tick;
        out_ready = 1'b0;
        settle;
        check("flush_empty", empty, 1);
        $display("txn flush done");

        // Reset mid-operation with committed entries
        push(50, 32'h60, 4'hF, 32'hE0);
        tick;
        push(51, 32'h64, 4'hF, 32'hE1);
        tick;
        push_valid = 1'b0;
        commit2(2'b11, 6'd51, 6'd50);
        tick;
        commit_valid = '0;
        settle;
        check("mid_out_valid", out_valid, 1);
        check("mid_count2", count, 2);
        rst = 1'b1;
        push(52, 32'h68, 4'hF, 32'hE2);
        out_ready = 1'b1; flush = 1'b1;
        commit2(2'b11, 6'd52, 6'd51);
        tick;
        rst = 1'b0; push_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; commit_valid = '0;
        settle;
        check("mid_rst_empty", empty, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_push_ready", push_ready, 1);
        check("mid_rst_count", count, 0);
        $display("txn mid-operation reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_queue_fwd.md
STORE_QUEUE_FWD -- requirements
Module: store_queue_fwd

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, 2..16.
REQ-002 SHALL have parameter DATA_W, default 32, store data width; 32 or 64.
REQ-003 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-004 SHALL have parameter ID_W, default 6, instruction ID width.
REQ-005 SHALL have parameter RETIRE_PORTS, default 2, commit ports per cycle; 1..4.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (reset).
REQ-007 SHALL have push_valid input 1, push_ready output 1, a store-enqueue handshake.
REQ-008 SHALL have push_addr input ADDR_W, push_be input DATA_W/8, push_data input DATA_W and push_id input ID_W, the store payload.
REQ-009 SHALL have commit_valid input RETIRE_PORTS and commit_id input RETIRE_PORTS*ID_W, carrying IDs that may now write memory.
REQ-010 SHALL have flush input 1, which discards all uncommitted entries.
REQ-011 SHALL have out_valid output 1 and out_ready input 1, the memory-issue handshake.
REQ-012 SHALL have out_addr output ADDR_W, out_be output DATA_W/8 and out_data output DATA_W, the oldest entry.
REQ-013 SHALL have ld_valid input 1, ld_addr input ADDR_W and ld_be input DATA_W/8, the load forwarding query.
REQ-014 SHALL have ld_hit output 1, ld_partial output 1 and ld_data output DATA_W, the forwarding result.
REQ-015 SHALL have empty output 1 and count output $clog2(DEPTH)+1, the occupancy.

Function
REQ-016 SHALL implement a circular FIFO with head/tail pointers that wrap modulo DEPTH, plus per-entry valid and committed bits.
REQ-017 SHALL drive push_ready = (count < DEPTH) from registered state only; a pop in the same cycle does not raise it.
REQ-018 SHALL write an entry at tail when push_valid&push_ready; the entry becomes valid next cycle with committed=0.
REQ-019 SHALL mark committed, each cycle, every valid uncommitted entry whose ID equals any commit_id[p] with commit_valid[p]=1; unmatched commit IDs are ignored.
REQ-020 SHALL not apply a commit to an entry being pushed in the same cycle; the environment guarantees commit arrives at least 1 cycle after push.
REQ-021 SHALL drive out_valid = valid[head] & committed[head], with out_* driven from the head entry combinationally.
REQ-022 SHALL pop when out_valid&out_ready: head increments, valid[head] is cleared next cycle, and payload is held while out_valid&~out_ready.
REQ-023 SHALL update count by +push -pop each cycle; simultaneous push and pop leave count unchanged.
REQ-024 On flush, SHALL clear all valid&~committed entries (after applying same-cycle commits), set tail=head+committed count, and discard any same-cycle push; a same-cycle pop still completes.
REQ-025 SHALL match forwarding on word address, i.e. ADDR_W bits above log2(DATA_W/8) equal, over valid entries including committed ones, excluding an entry popping this cycle.
REQ-026 For each byte b with ld_be[b]=1, SHALL take ld_data byte b from the youngest matching entry with be[b]=1; all other bytes are 0.
REQ-027 SHALL drive ld_hit=1 when ld_valid and every requested byte is supplied.
REQ-028 SHALL drive ld_partial=1 when ld_valid and some but not all requested bytes are supplied.
REQ-029 SHALL drive ld_hit and ld_partial low when ld_valid=0 or ld_be=0; the forwarding path is combinational with 0 cycles of latency.
REQ-030 SHALL determine age relative to head so that results are correct across pointer wrap.
REQ-031 SHALL drive empty = (count==0).

Reset
REQ-032 rst SHALL clear head, tail, count, all valid and committed bits; outputs after reset: push_ready=1, out_valid=0, empty=1, count=0, ld_hit=0, ld_partial=0.
REQ-033 rst asserted mid-operation SHALL drop all entries, including committed ones, and SHALL override push, commit, flush and pop in the same cycle.
REQ-034 Entry payload storage SHALL not require reset.

Verification
REQ-035 Basic flow, DEPTH=4, DATA_W=32: push id 3, addr 0x100, be 0xF, data 0xDEADBEEF; commit id 3 one cycle later; expect out_valid the next cycle with out_data 0xDEADBEEF; pop; expect empty=1.
REQ-036 Full and wrap: push 4 stores without commit -> push_ready=0 and count=4; commit all, pop 2, push 2 more -> tail wraps and FIFO order is preserved at out_*.
REQ-037 Byte forwarding: push addr 0x200 be 0x3 data 0x0000AAAA, then addr 0x200 be 0x2 data 0x0000BB00; load 0x200 be 0x3 -> ld_hit=1, ld_data 0x0000BBAA; load be 0xF -> ld_partial=1.
REQ-038 Flush: 3 entries with the oldest committed; flush with a simultaneous push -> count=1 next cycle, push discarded, committed entry still issues.
REQ-039 Simultaneous events: at count=DEPTH, pop and push_valid in the same cycle -> push refused and count=DEPTH-1; two commit ports matching two entries in one cycle -> both committed.
REQ-040 Reset mid-operation: assert rst with 2 committed entries -> next cycle empty=1, out_valid=0, push_ready=1.
